// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator control stage: opcodes, FSM states,
// instruction field widths and the decoded-opcode record.
package acc_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int IMM_W    = 8;
    localparam int INSTR_W  = OPCODE_W + IMM_W;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_TST  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_JC   = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_CALL = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_RET  = 4'hD;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef struct packed {
        logic is_alu;
        logic writes_acc;
        logic is_branch;
        logic is_halt;
        logic is_illegal;
    } dec_t;

endpackage

// File: rtl/acc_ctrl_if.sv
// Instruction-fetch and ALU connections of acc_ctrl; master is the control
// stage, slave is the instruction source plus the ALU.
interface acc_ctrl_if;
    import acc_ctrl_pkg::*;

    logic [7:0]         pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [7:0]         alu_a;
    logic [7:0]         alu_b;
    logic [3:0]         alu_sel;
    logic [7:0]         alu_result;
    logic               alu_cout;
    logic               alu_zout;

    modport master (
        output pc, instr_ready, alu_a, alu_b, alu_sel,
        input  instr_valid, instr, alu_result, alu_cout, alu_zout
    );

    modport slave (
        input  pc, instr_ready, alu_a, alu_b, alu_sel,
        output instr_valid, instr, alu_result, alu_cout, alu_zout
    );

endinterface

// File: rtl/acc_ctrl_decode.sv
// Opcode classifier for acc_ctrl. CALL/RET are legal branches only when
// ACC_CTRL_CALL_EN is defined; otherwise they decode as illegal.
module acc_ctrl_decode
    import acc_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output dec_t                dec
);

    always_comb begin
        // NOTE: default every field first so no path leaves one unassigned (no latch).
        dec = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_NOR, OP_SHR, OP_SHL, OP_LDI: begin
                dec.is_alu     = 1'b1;
                dec.writes_acc = 1'b1;
            end
            OP_TST:                   dec.is_alu    = 1'b1;
            OP_JMP, OP_JZ, OP_JC:     dec.is_branch = 1'b1;
`ifdef ACC_CTRL_CALL_EN
            OP_CALL, OP_RET:          dec.is_branch = 1'b1;
`endif
            OP_HALT:                  dec.is_halt   = 1'b1;
            OP_NOP:                   ;
            default:                  dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator control stage in front of the 8-bit ALU: fetch/exec/writeback FSM,
// pc, accumulator and flags. ACC_CTRL_CALL_EN adds single-level CALL/RET.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter logic [7:0] PC_RESET  = 8'h00,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    acc_ctrl_if.master    bus,
    output logic [7:0]    acc,
    output logic          flag_c,
    output logic          flag_z,
    output logic          halted,
    output logic          illegal
);

    state_t              state;
    logic [OPCODE_W-1:0] opcode;
    dec_t                dec_in;
    dec_t                dec_q;
    logic [7:0]          pc_inc;
    logic [7:0]          target;
    logic                taken;
`ifdef ACC_CTRL_CALL_EN
    logic [7:0]          ret_reg;
`endif

    acc_ctrl_decode u_decode (
        .opcode (bus.instr[INSTR_W-1:IMM_W]),
        .dec    (dec_in)
    );

    assign bus.alu_a = acc;
    assign pc_inc    = bus.pc + 8'd1;

    // Branch resolution uses the registered flags; alu_b holds the latched immediate.
    always_comb begin
        taken  = 1'b0;
        target = bus.alu_b;
        case (opcode)
            OP_JMP: taken = 1'b1;
            OP_JZ:  taken = flag_z;
            OP_JC:  taken = flag_c;
`ifdef ACC_CTRL_CALL_EN
            OP_CALL: taken = 1'b1;
            OP_RET: begin
                taken  = 1'b1;
                target = ret_reg;
            end
`endif
            default: ;
        endcase
        taken = taken & dec_q.is_branch;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FETCH;
            opcode          <= OP_NOP;
            dec_q           <= '0;
            bus.pc          <= PC_RESET;
            bus.alu_b       <= '0;
            bus.alu_sel     <= OP_NOP;
            bus.instr_ready <= 1'b1;
            acc             <= ACC_RESET;
            flag_c          <= 1'b0;
            flag_z          <= 1'b0;
            halted          <= 1'b0;
            illegal         <= 1'b0;
`ifdef ACC_CTRL_CALL_EN
            ret_reg         <= 8'h00;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (bus.instr_valid) begin
                        opcode          <= bus.instr[INSTR_W-1:IMM_W];
                        bus.alu_b       <= bus.instr[IMM_W-1:0];
                        dec_q           <= dec_in;
                        bus.alu_sel     <= dec_in.is_alu ? bus.instr[INSTR_W-1:IMM_W] : OP_NOP;
                        bus.instr_ready <= 1'b0;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_q.is_alu) begin
                        state <= WB;
                    end else if (dec_q.is_halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        bus.pc          <= taken ? target : pc_inc;
                        illegal         <= illegal | dec_q.is_illegal;
                        bus.instr_ready <= 1'b1;
                        state           <= FETCH;
`ifdef ACC_CTRL_CALL_EN
                        if (opcode == OP_CALL) ret_reg <= pc_inc;
`endif
                    end
                end
                WB: begin
                    flag_c <= bus.alu_cout;
                    flag_z <= bus.alu_zout;
                    if (dec_q.writes_acc) acc <= bus.alu_result;
                    bus.pc          <= pc_inc;
                    bus.alu_sel     <= OP_NOP;
                    bus.instr_ready <= 1'b1;
                    state           <= FETCH;
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: behavioural ALU on the bus plus an
// instruction-level model of the control stage (honours ACC_CTRL_CALL_EN).
module tb_acc_ctrl;
    import acc_ctrl_pkg::*;

    localparam logic [7:0] PC_RST  = 8'h00;
    localparam logic [7:0] ACC_RST = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] acc;
    logic       flag_c, flag_z, halted, illegal;

    acc_ctrl_if bus ();

    acc_ctrl #(.PC_RESET(PC_RST), .ACC_RESET(ACC_RST)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .acc     (acc),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Instruction-level model state.
    logic [7:0] m_pc, m_acc, m_ret;
    logic       m_c, m_z, m_illegal, m_halted;

    function automatic logic [8:0] alu_fn(input logic [3:0] sel, input logic [7:0] a,
                                          input logic [7:0] b);
        case (sel)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_NOR:  return {1'b0, ~(a | b)};
            OP_SHR:  return {a[0], 1'b0, a[7:1]};
            OP_SHL:  return {a[7], a[6:0], 1'b0};
            OP_TST:  return {1'b0, a};
            OP_LDI:  return {1'b0, b};
            default: return 9'h000;
        endcase
    endfunction

    logic [8:0] alu_r;
    always_comb begin
        alu_r          = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);
        bus.alu_result = alu_r[7:0];
        bus.alu_cout   = alu_r[8];
        bus.alu_zout   = (alu_r[7:0] == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL [%s] %s: got=%0h expected=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = PC_RST; m_acc = ACC_RST; m_ret = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_illegal = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [7:0] imm);
        logic [8:0] r;
        if (op >= OP_ADD && op <= OP_LDI) begin
            r   = alu_fn(op, m_acc, imm);
            m_c = r[8];
            m_z = (r[7:0] == 8'h00);
            if (op != OP_TST) m_acc = r[7:0];
            m_pc = m_pc + 8'd1;
        end else if (op == OP_JMP) m_pc = imm;
        else if (op == OP_JZ)   m_pc = m_z ? imm : m_pc + 8'd1;
        else if (op == OP_JC)   m_pc = m_c ? imm : m_pc + 8'd1;
        else if (op == OP_HALT) m_halted = 1'b1;
        else if (op == OP_NOP)  m_pc = m_pc + 8'd1;
`ifdef ACC_CTRL_CALL_EN
        else if (op == OP_CALL) begin m_ret = m_pc + 8'd1; m_pc = imm; end
        else if (op == OP_RET)  m_pc = m_ret;
`endif
        else begin
            m_illegal = 1'b1;
            m_pc      = m_pc + 8'd1;
        end
    endtask

    task automatic check_state();
        check("pc", bus.pc, m_pc);
        check("acc", acc, m_acc);
        check("flag_c", flag_c, m_c);
        check("flag_z", flag_z, m_z);
        check("illegal", illegal, m_illegal);
        check("halted", halted, m_halted);
        check("instr_ready", bus.instr_ready, !m_halted);
        check("alu_sel_idle", bus.alu_sel, OP_NOP);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [7:0] imm);
        int         n;
        int         lat;
        int         waited;
        logic [3:0] sel_exp;
        waited = 0;
        while (!bus.instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_issue", bus.instr_ready, 1);
        bus.instr       = {op, imm};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        sel_exp = (op >= OP_ADD && op <= OP_LDI) ? op : OP_NOP;
        lat     = (sel_exp != OP_NOP) ? 3 : 2;
        check("sel_exec", bus.alu_sel, sel_exp);
        check("alu_a", bus.alu_a, m_acc);
        check("alu_b", bus.alu_b, imm);
        check("ready_exec", bus.instr_ready, 0);
        n = 1;
        while (!bus.instr_ready && !halted && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (n == 2 && !bus.instr_ready && !halted) check("sel_wb", bus.alu_sel, sel_exp);
        end
        check("latency", n, lat);
        model_step(op, imm);
        check_state();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pc_hold, acc_hold;
        logic [3:0] op;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        phase = "reset";
        check_state();
        check("alu_b_reset", bus.alu_b, 8'h00);

        phase = "ldi_add_branch";
        run_instr(OP_LDI, 8'h0F);
        run_instr(OP_ADD, 8'hF1);
        run_instr(OP_JZ, 8'h40);
        run_instr(OP_LDI, 8'h01);
        run_instr(OP_JC, 8'h80);

        phase = "idle";
        pc_hold  = bus.pc;
        acc_hold = acc;
        repeat (5) begin
            @(posedge clk); #1;
            check("idle_pc", bus.pc, pc_hold);
            check("idle_acc", acc, acc_hold);
            check("idle_sel", bus.alu_sel, OP_NOP);
            check("idle_ready", bus.instr_ready, 1);
        end
        run_instr(OP_SHL, 8'h00);

        phase = "reset_in_wb";
        run_instr(OP_LDI, 8'h55);
        bus.instr       = {OP_SUB, 8'h11};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check("sel_wb_sub", bus.alu_sel, OP_SUB);
        do_reset();
        check_state();

        phase = "call_ret";
        run_instr(OP_JMP, 8'h05);
        run_instr(OP_CALL, 8'h20);
        run_instr(OP_RET, 8'h00);

        phase = "wrap_illegal";
        run_instr(OP_JMP, 8'hFF);
        run_instr(OP_NOP, 8'h00);
        run_instr(OP_LDI, 8'hA5);
        run_instr(4'hE, 8'h33);
        run_instr(4'hF, 8'h00);

        phase = "random";
        do_reset();
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_HALT) op = OP_NOP;
            run_instr(op, 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        phase = "halt";
        run_instr(OP_HALT, 8'h00);
        pc_hold         = bus.pc;
        bus.instr       = {OP_LDI, 8'h77};
        bus.instr_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("halt_ready", bus.instr_ready, 0);
            check("halt_flag", halted, 1);
            check("halt_pc", bus.pc, pc_hold);
        end
        do_reset();
        check_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
Accumulator-based control stage that sits directly upstream of the 8-bit ALU.
- Fetches 12-bit instructions over a valid/ready handshake and drives the ALU operands and the 4-bit select.
- Captures the ALU result and carry/zero flags into an accumulator and flag register.
- Maintains an 8-bit program counter with conditional branches and a halt state.

Parameters:
- PC_RESET, 8'h00, program counter value after reset.
- ACC_RESET, 8'h00, accumulator value after reset.

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high; all state cleared on the clock edge where reset=1
- pc  out  8  instruction fetch address
- instr_valid  in  1  instr holds a valid instruction for pc
- instr_ready  out  1  block accepts instr this cycle
- instr  in  12  [11:8] opcode, [7:0] immediate
- alu_a  out  8  ALU operand a (= accumulator)
- alu_b  out  8  ALU operand b (= latched immediate)
- alu_sel  out  4  ALU select
- alu_result  in  8  ALU result
- alu_cout  in  1  ALU carry
- alu_zout  in  1  ALU zero
- acc  out  8  accumulator
- flag_c  out  1  registered carry
- flag_z  out  1  registered zero
- halted  out  1  block is in HALT
- illegal  out  1  sticky: an undefined opcode was executed

Behaviour:
- Reset values: pc=PC_RESET, acc=ACC_RESET, flag_c=0, flag_z=0, halted=0, illegal=0, alu_sel=0000, alu_b=0, state=FETCH.
- Reset mid-instruction discards the instruction entirely; no partial writeback.

Opcode map (ALU select codes pass straight through as alu_sel):
- 0001 ADD, 0010 SUB, 0011 NOR, 0100 SHR, 0101 SHL
- 0110 TST: pass a; flags update, acc unchanged
- 0111 LDI: pass b
- 0000 NOP
- 1000 JMP imm; 1001 JZ imm (if flag_z); 1010 JC imm (if flag_c)
- 1011 HALT
- 1100–1111 undefined: act as NOP and set illegal

FSM states FETCH, EXEC, WB, HALT:
- FETCH: instr_ready=1. When instr_valid=1, latch opcode and immediate, then go to EXEC. If instr_valid=0, stay; no outputs change.
- EXEC: instr_ready=0; alu_a=acc, alu_b=imm.
  - ALU ops and TST drive alu_sel=opcode, then go to WB.
  - Branches, NOP and undefined opcodes keep alu_sel=0000. pc <= imm if the branch is taken, else pc+1; then go to FETCH.
  - HALT opcode: go to HALT.
- WB: alu_sel is still the opcode.
  - Capture flag_c<=alu_cout and flag_z<=alu_zout.
  - acc<=alu_result, except for TST.
  - pc<=pc+1, then go to FETCH.
- HALT: halted=1 and instr_ready=0; the block stays here until reset.

Timing and boundary rules:
- alu_sel is 0000 in every state except EXEC and WB.
- Latency: handshake cycle T; ALU op writes back at edge T+2; next fetch ready at T+3. Branch ready at T+2.
- pc increments modulo 256 (8'hFF -> 8'h00). A branch to the current pc is legal (a spin loop).
- Branch conditions use the registered flags at EXEC. The flags are never written in EXEC, so there is no hazard.
- Flags change only in WB of ALU/TST/LDI instructions.

Optional Feature:
Macro ACC_CTRL_CALL_EN.
- With it defined:
  - 1100 CALL imm: ret_reg<=pc+1 and pc<=imm.
  - 1101 RET: pc<=ret_reg.
  - ret_reg is a single level, reset to 0, and a nested CALL overwrites it.
  - Both take the branch timing (2 cycles).
  - illegal is raised only for 1110 and 1111.
- Without it: 1100 and 1101 are undefined opcodes (NOP plus illegal), and no ret_reg is built.

Decomposition:
- Package acc_ctrl_pkg contains:
  - 4-bit opcode localparams (OP_NOP … OP_RET)
  - the state enum (FETCH, EXEC, WB, HALT)
  - the instruction field widths
- Optional sub-module acc_ctrl_decode: combinational, opcode -> {is_alu, writes_acc, is_branch, is_halt, is_illegal}. The FSM, pc, acc and flag registers stay in the top level.

Test Plan:
The bench drives alu_result, alu_cout and alu_zout from a behavioural 8-bit ALU model.
- Reset then LDI 0x0F: alu_sel=0111 in EXEC and WB; acc=0x0F, flag_z=0, flag_c=0; pc=0x01; next instr_ready 3 cycles after the handshake.
- ADD 0xF1 after LDI 0x0F: acc=0x00, flag_c=1, flag_z=1; then JZ 0x40 gives pc=0x40 after 2 cycles; JC with flag_c=0 gives pc=pc+1.
- Hold instr_valid=0 for 5 cycles in FETCH: state, pc, acc and alu_sel=0000 all unchanged; resume correctly.
- Assert reset during WB of SUB: acc, flags and pc return to ACC_RESET, 0 and PC_RESET; the result is not written back.
- pc=0xFF NOP gives pc=0x00. HALT gives halted=1 and instr_ready stuck at 0 for 10 cycles, cleared by reset.
- Opcode 1110 sets illegal=1 and acc is unchanged. With ACC_CTRL_CALL_EN: CALL 0x20 at pc=0x05 then RET gives pc=0x06 and illegal=0; without the macro, 1100 sets illegal.
